// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: hazard/redirect controls in, fetch PC and flush controls out.
// The master side is the pipeline control logic; the slave side is pc_gen_unit.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             StallF;
    logic             PCSrcE;
    logic [XLEN-1:0]  JumpTargetE;
    logic             TrapE;
    logic [XLEN-1:0]  TrapVec;
    logic [XLEN-1:0]  PCF;
    logic [XLEN-1:0]  PCplus4F;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] RedirectCnt;
    logic             MisalignF;

    modport master (
        output StallF, PCSrcE, JumpTargetE, TrapE, TrapVec,
        input  PCF, PCplus4F, FlushD, FlushE, RedirectCnt, MisalignF
    );

    modport slave (
        input  StallF, PCSrcE, JumpTargetE, TrapE, TrapVec,
        output PCF, PCplus4F, FlushD, FlushE, RedirectCnt, MisalignF
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter: next-PC select, redirect flush pulses and saturating redirect counter.
// Optional macro MISALIGN_CHK_EN: misaligned branch/jump targets are diverted to TrapVec and flagged.
module pc_gen_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          INC       = 4,
    parameter int          CNT_W     = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  pc_bus
);
    localparam logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(INC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  pc_next;
    logic             redirect;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q;

    assign pc_plus = pc_q + PC_STEP;
    assign redirect = pc_bus.TrapE | pc_bus.PCSrcE;

`ifdef MISALIGN_CHK_EN
    logic misalign_next;
    logic misalign_q;

    // Redirects outrank the stall so a resolved branch is never dropped.
    always_comb begin
        pc_next       = pc_plus;
        misalign_next = 1'b0;
        if (pc_bus.TrapE) begin
            pc_next = pc_bus.TrapVec;
        end else if (pc_bus.PCSrcE) begin
            if (pc_bus.JumpTargetE[1:0] != 2'b00) begin
                pc_next       = pc_bus.TrapVec;
                misalign_next = 1'b1;
            end else begin
                pc_next = pc_bus.JumpTargetE;
            end
        end else if (pc_bus.StallF) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_next;
        end
    end

    assign pc_bus.MisalignF = misalign_q;
`else
    always_comb begin
        pc_next = pc_plus;
        if (pc_bus.TrapE) begin
            pc_next = pc_bus.TrapVec;
        end else if (pc_bus.PCSrcE) begin
            pc_next = pc_bus.JumpTargetE;
        end else if (pc_bus.StallF) begin
            pc_next = pc_q;
        end
    end

    assign pc_bus.MisalignF = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_next;
            flush_q <= redirect;
            if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign pc_bus.PCF         = pc_q;
    assign pc_bus.PCplus4F    = pc_plus;
    assign pc_bus.FlushD      = flush_q;
    assign pc_bus.FlushE      = flush_q;
    assign pc_bus.RedirectCnt = cnt_q;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a default-width instance plus a CNT_W=2 instance for saturation.
module tb_pc_gen_unit;
    logic clk;
    logic rst;
    int   vec_count;
    int   err_count;

    pc_gen_if #(.XLEN(32), .CNT_W(16)) bus ();
    pc_gen_if #(.XLEN(32), .CNT_W(2))  sat_bus ();

    pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus)
    );

    pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .CNT_W(2)) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (sat_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.StallF          = 1'b0;
        bus.PCSrcE          = 1'b0;
        bus.JumpTargetE     = '0;
        bus.TrapE           = 1'b0;
        bus.TrapVec         = '0;
        sat_bus.StallF      = 1'b0;
        sat_bus.PCSrcE      = 1'b0;
        sat_bus.JumpTargetE = '0;
        sat_bus.TrapE       = 1'b0;
        sat_bus.TrapVec     = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst = 1'b1;
        step();
        step();
        vec_count++;
        if (bus.PCF !== 32'h0) begin
            err_count++;
            $display("[TB] FAIL reset_pcf got %h want %h", bus.PCF, 32'h0);
        end
        vec_count++;
        if (bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL reset_flush got %b%b want 00", bus.FlushD, bus.FlushE);
        end
        vec_count++;
        if (bus.RedirectCnt !== 16'd0) begin
            err_count++;
            $display("[TB] FAIL reset_cnt got %0d want 0", bus.RedirectCnt);
        end
        vec_count++;
        if (bus.MisalignF !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL reset_misalign got %b want 0", bus.MisalignF);
        end
        rst = 1'b0;
        vec_count++;
        if (bus.PCplus4F !== 32'h4) begin
            err_count++;
            $display("[TB] FAIL reset_pcplus4 got %h want %h", bus.PCplus4F, 32'h4);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            vec_count++;
            if (bus.PCF !== exp_pc) begin
                err_count++;
                $display("[TB] FAIL seq_pcf[%0d] got %h want %h", i, bus.PCF, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        step();
        vec_count++;
        if (bus.PCF !== 32'h10) begin
            err_count++;
            $display("[TB] FAIL stall_setup got %h want %h", bus.PCF, 32'h10);
        end
        bus.StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_count++;
            if (bus.PCF !== 32'h10 || bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0) begin
                err_count++;
                $display("[TB] FAIL stall_hold[%0d] got pc=%h fl=%b%b want pc=%h fl=00",
                         i, bus.PCF, bus.FlushD, bus.FlushE, 32'h10);
            end
        end
        bus.StallF = 1'b0;
        step();
        vec_count++;
        if (bus.PCF !== 32'h14) begin
            err_count++;
            $display("[TB] FAIL stall_release got %h want %h", bus.PCF, 32'h14);
        end
    endtask

    task automatic test_branch_vs_stall();
        step();
        step();
        step();
        vec_count++;
        if (bus.PCF !== 32'h20) begin
            err_count++;
            $display("[TB] FAIL branch_setup got %h want %h", bus.PCF, 32'h20);
        end
        bus.PCSrcE      = 1'b1;
        bus.JumpTargetE = 32'h100;
        bus.StallF      = 1'b1;
        step();
        bus.PCSrcE = 1'b0;
        bus.StallF = 1'b0;
        vec_count++;
        if (bus.PCF !== 32'h100 || bus.FlushD !== 1'b1 || bus.FlushE !== 1'b1 ||
            bus.RedirectCnt !== 16'd1 || bus.MisalignF !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL branch_redirect got pc=%h fl=%b%b cnt=%0d mis=%b want pc=%h fl=11 cnt=1 mis=0",
                     bus.PCF, bus.FlushD, bus.FlushE, bus.RedirectCnt, bus.MisalignF, 32'h100);
        end
        step();
        vec_count++;
        if (bus.PCF !== 32'h104 || bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0 ||
            bus.RedirectCnt !== 16'd1) begin
            err_count++;
            $display("[TB] FAIL branch_after got pc=%h fl=%b%b cnt=%0d want pc=%h fl=00 cnt=1",
                     bus.PCF, bus.FlushD, bus.FlushE, bus.RedirectCnt, 32'h104);
        end
    endtask

    task automatic test_trap_priority();
        bus.TrapE       = 1'b1;
        bus.TrapVec     = 32'h80;
        bus.PCSrcE      = 1'b1;
        bus.JumpTargetE = 32'h200;
        step();
        bus.TrapE  = 1'b0;
        bus.PCSrcE = 1'b0;
        vec_count++;
        if (bus.PCF !== 32'h80 || bus.RedirectCnt !== 16'd2 || bus.FlushD !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL trap_priority got pc=%h cnt=%0d fd=%b want pc=%h cnt=2 fd=1",
                     bus.PCF, bus.RedirectCnt, bus.FlushD, 32'h80);
        end
    endtask

    task automatic test_back_to_back();
        bus.PCSrcE      = 1'b1;
        bus.JumpTargetE = 32'h300;
        step();
        vec_count++;
        if (bus.PCF !== 32'h300 || bus.FlushD !== 1'b1 || bus.FlushE !== 1'b1 ||
            bus.RedirectCnt !== 16'd3) begin
            err_count++;
            $display("[TB] FAIL b2b_first got pc=%h fl=%b%b cnt=%0d want pc=%h fl=11 cnt=3",
                     bus.PCF, bus.FlushD, bus.FlushE, bus.RedirectCnt, 32'h300);
        end
        bus.JumpTargetE = 32'h400;
        step();
        bus.PCSrcE = 1'b0;
        vec_count++;
        if (bus.PCF !== 32'h400 || bus.FlushD !== 1'b1 || bus.FlushE !== 1'b1 ||
            bus.RedirectCnt !== 16'd4) begin
            err_count++;
            $display("[TB] FAIL b2b_second got pc=%h fl=%b%b cnt=%0d want pc=%h fl=11 cnt=4",
                     bus.PCF, bus.FlushD, bus.FlushE, bus.RedirectCnt, 32'h400);
        end
        step();
        vec_count++;
        if (bus.PCF !== 32'h404 || bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL b2b_after got pc=%h fl=%b%b want pc=%h fl=00",
                     bus.PCF, bus.FlushD, bus.FlushE, 32'h404);
        end
    endtask

    task automatic test_reset_mid();
        bus.PCSrcE      = 1'b1;
        bus.JumpTargetE = 32'h500;
        rst             = 1'b1;
        step();
        rst        = 1'b0;
        bus.PCSrcE = 1'b0;
        vec_count++;
        if (bus.PCF !== 32'h0 || bus.FlushD !== 1'b0 || bus.RedirectCnt !== 16'd0) begin
            err_count++;
            $display("[TB] FAIL reset_mid got pc=%h fd=%b cnt=%0d want pc=0 fd=0 cnt=0",
                     bus.PCF, bus.FlushD, bus.RedirectCnt);
        end
        step();
        vec_count++;
        if (bus.PCF !== 32'h4 || bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL reset_mid_after got pc=%h fl=%b%b want pc=%h fl=00",
                     bus.PCF, bus.FlushD, bus.FlushE, 32'h4);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_next;
        logic        exp_mis;
`ifdef MISALIGN_CHK_EN
        exp_pc      = 32'h80;
        exp_pc_next = 32'h84;
        exp_mis     = 1'b1;
`else
        exp_pc      = 32'h102;
        exp_pc_next = 32'h106;
        exp_mis     = 1'b0;
`endif
        bus.PCSrcE      = 1'b1;
        bus.JumpTargetE = 32'h102;
        bus.TrapVec     = 32'h80;
        step();
        bus.PCSrcE = 1'b0;
        vec_count++;
        if (bus.PCF !== exp_pc || bus.MisalignF !== exp_mis || bus.FlushD !== 1'b1 ||
            bus.RedirectCnt !== 16'd1) begin
            err_count++;
            $display("[TB] FAIL misalign got pc=%h mis=%b fd=%b cnt=%0d want pc=%h mis=%b fd=1 cnt=1",
                     bus.PCF, bus.MisalignF, bus.FlushD, bus.RedirectCnt, exp_pc, exp_mis);
        end
        step();
        vec_count++;
        if (bus.PCF !== exp_pc_next || bus.MisalignF !== 1'b0) begin
            err_count++;
            $display("[TB] FAIL misalign_after got pc=%h mis=%b want pc=%h mis=0",
                     bus.PCF, bus.MisalignF, exp_pc_next);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        exp_cnt = 2'd0;
        sat_bus.PCSrcE      = 1'b1;
        sat_bus.JumpTargetE = 32'h40;
        for (int i = 0; i < 5; i++) begin
            step();
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            vec_count++;
            if (sat_bus.RedirectCnt !== exp_cnt) begin
                err_count++;
                $display("[TB] FAIL sat_cnt[%0d] got %0d want %0d", i, sat_bus.RedirectCnt, exp_cnt);
            end
        end
        sat_bus.JumpTargetE = 32'hFFFF_FFFC;
        step();
        sat_bus.PCSrcE = 1'b0;
        vec_count++;
        if (sat_bus.PCF !== 32'hFFFF_FFFC || sat_bus.PCplus4F !== 32'h0 ||
            sat_bus.RedirectCnt !== 2'd3) begin
            err_count++;
            $display("[TB] FAIL wrap_setup got pc=%h p4=%h cnt=%0d want pc=%h p4=0 cnt=3",
                     sat_bus.PCF, sat_bus.PCplus4F, sat_bus.RedirectCnt, 32'hFFFF_FFFC);
        end
        step();
        vec_count++;
        if (sat_bus.PCF !== 32'h0 || sat_bus.RedirectCnt !== 2'd3) begin
            err_count++;
            $display("[TB] FAIL wrap_pcf got pc=%h cnt=%0d want pc=0 cnt=3",
                     sat_bus.PCF, sat_bus.RedirectCnt);
        end
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        rst       = 1'b1;
        clear_inputs();
        test_reset();
        test_stall();
        test_branch_vs_stall();
        test_trap_priority();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Fetch-stage program counter generator: holds the PC register and selects the next PC.
- Sources are sequential (+INC), branch/jump redirect from Execute, trap redirect, and stall hold.
- Generates the one-cycle Decode/Execute flush pulses on redirect and keeps a saturating redirect counter for performance monitoring.
- Sits in front of instruction memory and feeds the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (truncated/zero-extended to XLEN).
- INC, 4, sequential increment in bytes.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- StallF  input  1  hazard unit: hold PC.
- PCSrcE  input  1  Execute: branch taken / jump.
- JumpTargetE  input  XLEN  Execute redirect target.
- TrapE  input  1  trap/exception request.
- TrapVec  input  XLEN  trap handler address.
- PCF  output  XLEN  current fetch PC.
- PCplus4F  output  XLEN  PCF + INC.
- FlushD  output  1  flush IF/ID register.
- FlushE  output  1  flush ID/EX register.
- RedirectCnt  output  CNT_W  count of redirects taken.
- MisalignF  output  1  misaligned-target flag (MISALIGN_CHK_EN only; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state updates on the rising clk edge.
- Reset values: PCF=RESET_VEC, FlushD=0, FlushE=0, RedirectCnt=0, MisalignF=0. rst has priority over all other inputs in the same cycle.
- Reset mid-operation: rst asserted while a redirect is pending discards the redirect; no flush is emitted.
- PCplus4F is combinational: PCF+INC, modulo 2^XLEN. Wrap-around from all-ones is allowed and no flag is raised.
- Next-PC priority (highest first):
  1. rst -> RESET_VEC
  2. TrapE -> TrapVec
  3. PCSrcE -> JumpTargetE
  4. StallF -> PCF (hold)
  5. otherwise -> PCplus4F
- A redirect (TrapE or PCSrcE) overrides StallF: a resolved branch must not be lost to a stall.
- Latency: a redirect asserted in cycle N makes PCF equal the target in cycle N+1.
- Flush outputs are registered. A redirect in cycle N gives FlushD=1 and FlushE=1 in cycle N+1, for exactly one cycle, then 0 unless another redirect occurs.
- Back-to-back redirects keep the flushes high continuously.
- StallF alone never asserts a flush.
- TrapE and PCSrcE together: trap target wins; one redirect is counted, not two.
- RedirectCnt increments by 1 on each cycle with a redirect and rst=0. It saturates at all-ones and does not wrap.
- No handshake; every input is sampled each cycle.

Optional Feature:
- Macro: MISALIGN_CHK_EN.
- Defined:
  - The chosen redirect target (TrapVec excluded) is checked for alignment.
  - If JumpTargetE[1:0] != 2'b00, next PC = TrapVec instead, and MisalignF=1 for one cycle in N+1.
  - Flushes and counter behave as for a normal redirect.
- Undefined: no check; the misaligned target is loaded as-is; MisalignF is constant 0.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_VEC=0 -> PCF=0, FlushD/FlushE=0, RedirectCnt=0. Release rst -> PCF=0,4,8,12 on successive cycles.
- Stall: at PCF=0x10 hold StallF=1 for 3 cycles -> PCF stays 0x10, no flushes. Drop StallF -> PCF=0x14.
- Branch vs stall: PCF=0x20, PCSrcE=1, JumpTargetE=0x100, StallF=1 together -> next PCF=0x100, FlushD=FlushE=1 for exactly 1 cycle, RedirectCnt=1.
- Trap priority: TrapE=1, TrapVec=0x80, PCSrcE=1, JumpTargetE=0x200 -> PCF=0x80, RedirectCnt increments by 1 only.
- Saturation: CNT_W=2, 5 consecutive redirects -> RedirectCnt=3 and holds. PCF=0xFFFF_FFFC with no stall -> next PCF=0x0.
- MISALIGN_CHK_EN defined: PCSrcE=1, JumpTargetE=0x102, TrapVec=0x80 -> PCF=0x80, MisalignF=1 for 1 cycle. Undefined -> PCF=0x102, MisalignF=0.
